// File: rtl/aes128_round_ctrl_if.sv
// Block-level stream interface of the AES-128 round controller:
// plaintext/key input handshake and ciphertext output handshake.
interface aes128_round_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  // Producer of plaintext and consumer of ciphertext.
  modport master (
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data
  );

  // The round controller itself.
  modport slave (
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes128_round_ctrl.sv
// AES-128 encryption round sequencer. Performs the initial AddRoundKey,
// steps external round units through rounds 1..10 (each round held for
// ROUND_LAT+1 cycles), then holds the ciphertext until it is taken.
// One block in flight at a time.
module aes128_round_ctrl #(
  parameter int ROUND_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  aes128_round_ctrl_if.slave  bus,
  output logic                busy,
  output logic [3:0]          rnd_num,
  output logic [127:0]        rnd_data,
  output logic [127:0]        rnd_key,
  input  logic [127:0]        rnd_out_data,
  input  logic [127:0]        rnd_out_key,
  input  logic [127:0]        fin_out_data
);

  // wait_cnt is only two bits wide, so larger latencies cannot be counted.
  if (ROUND_LAT < 0 || ROUND_LAT > 3) begin : g_bad_lat
    $error("aes128_round_ctrl: ROUND_LAT must be in 0..3");
  end

  localparam logic [1:0] LAST_WAIT  = 2'(ROUND_LAT);
  localparam logic [3:0] LAST_ROUND = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_t;

  state_t       state_reg, state_next;
  logic [3:0]   round_reg, round_next;
  logic [1:0]   wait_reg,  wait_next;
  logic [127:0] data_reg,  data_next;
  logic [127:0] key_reg,   key_next;
  logic [127:0] out_reg,   out_next;

  // Round inputs come straight from registers so they stay stable for a round.
  assign rnd_data     = data_reg;
  assign rnd_key      = key_reg;
  assign bus.out_data = out_reg;

  // State and datapath registers; reset aborts any block in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      round_reg <= 4'd0;
      wait_reg  <= 2'd0;
      data_reg  <= 128'd0;
      key_reg   <= 128'd0;
      out_reg   <= 128'd0;
    end else begin
      state_reg <= state_next;
      round_reg <= round_next;
      wait_reg  <= wait_next;
      data_reg  <= data_next;
      key_reg   <= key_next;
      out_reg   <= out_next;
    end
  end

  // Next-state, round capture and handshake outputs.
  always_comb begin
    state_next    = state_reg;
    round_next    = round_reg;
    wait_next     = wait_reg;
    data_next     = data_reg;
    key_next      = key_reg;
    out_next      = out_reg;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b1;
    rnd_num       = 4'd0;

    case (state_reg)
      IDLE: begin
        bus.in_ready = 1'b1;
        busy         = 1'b0;
        if (bus.in_valid) begin
          // Initial AddRoundKey happens on the way into the state register.
          data_next  = bus.in_data ^ bus.in_key;
          key_next   = bus.in_key;
          round_next = 4'd1;
          wait_next  = 2'd0;
          state_next = ROUND;
        end
      end

      ROUND: begin
        rnd_num = round_reg;
        if (wait_reg == LAST_WAIT) begin
          wait_next = 2'd0;
          if (round_reg == LAST_ROUND) begin
            out_next   = fin_out_data;
            state_next = DONE;
          end else begin
            data_next  = rnd_out_data;
            key_next   = rnd_out_key;
            round_next = round_reg + 4'd1;
          end
        end else begin
          wait_next = wait_reg + 2'd1;
        end
      end

      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          round_next = 4'd0;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Bench for aes128_round_ctrl: one instance with real AES round units
// (ROUND_LAT=1) and one with an arithmetic stub unit (ROUND_LAT=0).
module tb_aes128_round_ctrl;

  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_R1   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] C_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  bit   sel;

  logic         drv_valid;
  logic         drv_out_ready;
  logic [127:0] drv_data;
  logic [127:0] drv_key;

  aes128_round_ctrl_if bus_a ();
  aes128_round_ctrl_if bus_b ();

  logic         a_busy, b_busy;
  logic [3:0]   a_rnd_num, b_rnd_num;
  logic [127:0] a_rnd_data, a_rnd_key, b_rnd_data, b_rnd_key;
  logic [127:0] a_rnd_out_data, a_rnd_out_key, a_fin_out_data;
  logic [127:0] b_rnd_out_data, b_rnd_out_key, b_fin_out_data;
  logic [127:0] a_d_q, a_k_q;
  logic [3:0]   a_n_q;

  logic         v_in_ready, v_out_valid, v_busy;
  logic [3:0]   v_rnd_num;
  logic [127:0] v_out_data, v_rnd_data, v_rnd_key;

  logic [127:0] exp_st [1:10];
  logic [127:0] exp_k  [1:10];
  logic [127:0] exp_ct;
  logic [127:0] last_ct, r1_data, r1_key;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- AES reference helpers ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] t, inv;
    t = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      t = gmul(t, t);
      inv = gmul(inv, t);
    end
    if (x == 8'h00) inv = 8'h00;
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] byt(input logic [127:0] s, input int i);
    return s[127 - 8 * i -: 8];
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127 - 8 * (r + 4 * c) -: 8] = sbox(byt(s, r + 4 * ((c + r) % 4)));
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = byt(s, 4 * c);
      a1 = byt(s, 4 * c + 1);
      a2 = byt(s, 4 * c + 2);
      a3 = byt(s, 4 * c + 3);
      o[127 - 32 * c -: 32] = {
        gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3,
        a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3,
        a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3),
        gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2)};
    end
    return o;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [3:0] rnd);
    logic [7:0]  rcon;
    logic [31:0] rot, t, n0, n1, n2, n3;
    rcon = 8'h01;
    for (int i = 1; i < int'(rnd); i++) rcon = gmul(rcon, 8'h02);
    rot = {k[23:0], k[31:24]};
    t = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rcon, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- round units ----------------
  // Real AES units with one cycle of latency: results follow inputs one edge late.
  always @(posedge clk) begin
    a_d_q <= a_rnd_data;
    a_k_q <= a_rnd_key;
    a_n_q <= a_rnd_num;
  end
  assign a_rnd_out_key  = key_step(a_k_q, a_n_q);
  assign a_rnd_out_data = mix_cols(sub_shift(a_d_q)) ^ a_rnd_out_key;
  assign a_fin_out_data = sub_shift(a_d_q) ^ a_rnd_out_key;

  // Combinational stub units: data advances by the round number, key by one.
  assign b_rnd_out_data = b_rnd_data + {124'd0, b_rnd_num};
  assign b_rnd_out_key  = b_rnd_key + 128'd1;
  assign b_fin_out_data = b_rnd_data + b_rnd_key;

  // ---------------- stimulus routing ----------------
  assign bus_a.in_valid  = drv_valid & ~sel;
  assign bus_b.in_valid  = drv_valid & sel;
  assign bus_a.in_data   = drv_data;
  assign bus_b.in_data   = drv_data;
  assign bus_a.in_key    = drv_key;
  assign bus_b.in_key    = drv_key;
  assign bus_a.out_ready = drv_out_ready & ~sel;
  assign bus_b.out_ready = drv_out_ready & sel;

  assign v_in_ready  = sel ? bus_b.in_ready  : bus_a.in_ready;
  assign v_out_valid = sel ? bus_b.out_valid : bus_a.out_valid;
  assign v_out_data  = sel ? bus_b.out_data  : bus_a.out_data;
  assign v_busy      = sel ? b_busy          : a_busy;
  assign v_rnd_num   = sel ? b_rnd_num       : a_rnd_num;
  assign v_rnd_data  = sel ? b_rnd_data      : a_rnd_data;
  assign v_rnd_key   = sel ? b_rnd_key       : a_rnd_key;

  aes128_round_ctrl #(.ROUND_LAT(1)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_a),
    .busy         (a_busy),
    .rnd_num      (a_rnd_num),
    .rnd_data     (a_rnd_data),
    .rnd_key      (a_rnd_key),
    .rnd_out_data (a_rnd_out_data),
    .rnd_out_key  (a_rnd_out_key),
    .fin_out_data (a_fin_out_data)
  );

  aes128_round_ctrl #(.ROUND_LAT(0)) u_stub_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_b),
    .busy         (b_busy),
    .rnd_num      (b_rnd_num),
    .rnd_data     (b_rnd_data),
    .rnd_key      (b_rnd_key),
    .rnd_out_data (b_rnd_out_data),
    .rnd_out_key  (b_rnd_out_key),
    .fin_out_data (b_fin_out_data)
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  // Reference: the state and previous key presented in every round, and the result.
  task automatic model(input bit stub, input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s, k;
    s = pt ^ key;
    k = key;
    for (int r = 1; r <= 10; r++) begin
      exp_st[r] = s;
      exp_k[r]  = k;
      if (stub) begin
        if (r < 10) begin
          s = s + 128'(r);
          k = k + 128'd1;
        end else begin
          exp_ct = s + k;
        end
      end else begin
        k = key_step(k, 4'(r));
        s = (r < 10) ? (mix_cols(sub_shift(s)) ^ k) : (sub_shift(s) ^ k);
        if (r == 10) exp_ct = s;
      end
    end
  endtask

  // Waits (bounded) for in_ready, offers a block and checks it was taken.
  task automatic accept(input logic [127:0] pt, input logic [127:0] key);
    int t;
    t = 0;
    while (!v_in_ready && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("accept_ready", {127'd0, v_in_ready}, 128'd1);
    model(sel, pt, key);
    drv_data  = pt;
    drv_key   = key;
    drv_valid = 1'b1;
    @(posedge clk); #1;
    // keep offering junk: it must be ignored while busy
    drv_data = rand128();
    drv_key  = rand128();
    check_eq("busy_after_accept", {127'd0, v_busy}, 128'd1);
    check_eq("in_ready_busy", {127'd0, v_in_ready}, 128'd0);
  endtask

  task automatic run_block(input logic [127:0] pt, input logic [127:0] key, input int hold,
                           input bit nxt_valid, input logic [127:0] nxt_pt,
                           input logic [127:0] nxt_key);
    int lat;
    lat = sel ? 1 : 2;
    drv_out_ready = 1'b0;
    accept(pt, key);
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < lat; c++) begin
        if (r == 1 && c == 0) begin
          r1_data = v_rnd_data;
          r1_key  = v_rnd_key;
        end
        check_eq("rnd_num", {124'd0, v_rnd_num}, 128'(r));
        check_eq("rnd_data", v_rnd_data, exp_st[r]);
        check_eq("rnd_key", v_rnd_key, exp_k[r]);
        check_eq("early_out_valid", {127'd0, v_out_valid}, 128'd0);
        @(posedge clk); #1;
      end
    end
    check_eq("out_valid_latency", {127'd0, v_out_valid}, 128'd1);
    check_eq("out_data", v_out_data, exp_ct);
    last_ct = v_out_data;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_eq("hold_out_valid", {127'd0, v_out_valid}, 128'd1);
      check_eq("hold_out_data", v_out_data, exp_ct);
      check_eq("hold_in_ready", {127'd0, v_in_ready}, 128'd0);
    end
    drv_out_ready = 1'b1;
    drv_valid     = nxt_valid;
    drv_data      = nxt_pt;
    drv_key       = nxt_key;
    @(posedge clk); #1;
    drv_out_ready = 1'b0;
    check_eq("post_hs_out_valid", {127'd0, v_out_valid}, 128'd0);
    check_eq("post_hs_in_ready", {127'd0, v_in_ready}, 128'd1);
    check_eq("post_hs_busy", {127'd0, v_busy}, 128'd0);
    check_eq("post_hs_rnd_num", {124'd0, v_rnd_num}, 128'd0);
    $display("block dut=%0d pt=%h key=%h ct=%h hold=%0d", sel, pt, key, last_ct, hold);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [127:0] rpt [0:5];
    logic [127:0] rkey[0:5];
    int t;
    checks = 0;
    errors = 0;
    sel = 1'b0;
    rst_n = 1'b0;
    drv_valid = 1'b0;
    drv_out_ready = 1'b0;
    drv_data = '0;
    drv_key = '0;
    repeat (3) @(posedge clk);
    #1;

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check_eq("rst_in_ready", {127'd0, v_in_ready}, 128'd1);
      check_eq("rst_out_valid", {127'd0, v_out_valid}, 128'd0);
      check_eq("rst_busy", {127'd0, v_busy}, 128'd0);
      check_eq("rst_rnd_num", {124'd0, v_rnd_num}, 128'd0);
      check_eq("rst_out_data", v_out_data, 128'd0);
      check_eq("rst_rnd_data", v_rnd_data, 128'd0);
    end
    sel = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // App. B then App. C.1, back to back with in_valid held high
    run_block(B_PT, B_KEY, 0, 1'b1, C_PT, C_KEY);
    check_eq("appb_r1_data", r1_data, B_R1);
    check_eq("appb_r1_key", r1_key, B_KEY);
    check_eq("appb_ct", last_ct, B_CT);
    run_block(C_PT, C_KEY, 0, 1'b0, '0, '0);
    check_eq("appc1_ct", last_ct, C_CT);

    // Backpressure: consumer stalls for 7 cycles
    run_block(C_PT, C_KEY, 7, 1'b0, '0, '0);
    check_eq("bp_ct", last_ct, C_CT);

    // Reset in the middle of round 5
    accept(C_PT, C_KEY);
    t = 0;
    while (v_rnd_num != 4'd5 && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("reach_round5", {124'd0, v_rnd_num}, 128'd5);
    drv_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("midrst_in_ready", {127'd0, v_in_ready}, 128'd1);
    check_eq("midrst_out_valid", {127'd0, v_out_valid}, 128'd0);
    check_eq("midrst_rnd_num", {124'd0, v_rnd_num}, 128'd0);
    check_eq("midrst_busy", {127'd0, v_busy}, 128'd0);
    check_eq("midrst_out_data", v_out_data, 128'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("midrst_idle_valid", {127'd0, v_out_valid}, 128'd0);
      check_eq("midrst_idle_ready", {127'd0, v_in_ready}, 128'd1);
    end
    run_block(C_PT, C_KEY, 0, 1'b0, '0, '0);
    check_eq("post_rst_ct", last_ct, C_CT);

    // Randomized blocks on both instances
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      @(posedge clk); #1;
      for (int i = 0; i < 6; i++) begin
        rpt[i]  = rand128();
        rkey[i] = rand128();
      end
      for (int i = 0; i < 5; i++) begin
        run_block(rpt[i], rkey[i], int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  rpt[i + 1], rkey[i + 1]);
      end
      drv_valid = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes128_round_ctrl.md
Name: aes128_round_ctrl

Overview:
- Sequencing stage directly upstream of the per-round datapath for AES-128 encryption.
- Accepts one plaintext/key pair over a valid/ready handshake and performs the initial AddRoundKey.
- Drives the round iteration unit for rounds 1–9 and the final-round unit (no MixColumns) for round 10, capturing each round's state and round key.
- Presents the ciphertext over a valid/ready output handshake. One block in flight; no pipelining across blocks.

Parameters:
ROUND_LAT, 1, cycles from stable rnd_* inputs to valid round-unit outputs (0 = combinational units); legal range 0–3.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  plaintext/key offered
in_ready  out  1  controller can accept a block
in_data  in  128  plaintext, byte 0 in [127:120]
in_key  in  128  cipher key, same byte order
out_valid  out  1  ciphertext available
out_ready  in  1  consumer takes ciphertext
out_data  out  128  ciphertext
busy  out  1  high from acceptance until out handshake completes
rnd_num  out  4  current round number 1–10; 0 when idle
rnd_data  out  128  state presented to the round units
rnd_key  out  128  previous round key presented to the round units
rnd_out_data  in  128  state result from the round iteration unit (rounds 1–9)
rnd_out_key  in  128  round key generated for rnd_num
fin_out_data  in  128  state result from the final-round unit (round 10)

Behaviour:
- Reset: when rst_n=0 at a clk edge, the controller returns to IDLE.
  - Outputs after reset: in_ready=1, out_valid=0, busy=0, rnd_num=0.
  - State, key and output registers clear to 0.
  - Reset mid-operation aborts the block; no partial output is produced.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, the next edge loads state_reg=in_data^in_key and key_reg=in_key, sets round=1 and wait_cnt=0, and moves to ROUND.
- ROUND:
  - in_ready=0. rnd_num=round, rnd_data=state_reg, rnd_key=key_reg. All three are held stable for the whole round.
  - wait_cnt increments each cycle. At the edge where wait_cnt==ROUND_LAT, the controller captures results.
  - Capture for round<10: state_reg<=rnd_out_data, key_reg<=rnd_out_key, round+1, wait_cnt<=0.
  - Capture for round==10: out_data<=fin_out_data, then go to DONE.
  - Each round therefore lasts ROUND_LAT+1 cycles.
- Latency: out_valid rises exactly 10*(ROUND_LAT+1) cycles after the acceptance edge (20 cycles at default).
- DONE:
  - out_valid=1; out_data is held stable until out_valid&out_ready.
  - On that handshake edge: go to IDLE, out_valid=0, busy=0.
  - in_ready becomes 1 the cycle after the handshake; acceptance and output never occur in the same cycle.
- Backpressure: out_ready low holds DONE indefinitely. in_valid is ignored outside IDLE.
- Round counter width: 4 bits, never exceeding 10. wait_cnt is 2 bits.
- No arithmetic beyond XOR. No data-dependent timing.

Test Plan:
- FIPS-197 App. C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, with real round units, ROUND_LAT=1, out_ready=1.
  - Required: out_data=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 20 cycles after acceptance.
- FIPS-197 App. B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
  - Required: in round 1, rnd_data=193de3bea0f4e22b9ac68d2ae9f84808 and rnd_key=2b7e1516…4f3c; final out_data=3925841d02dc09fbdc118597196a0b32.
- Sequencing with a stub round unit (output = input+1 pattern, ROUND_LAT=0):
  - rnd_num steps 1..10 one per cycle; rnd_data and rnd_key are stable within each round.
  - out_valid rises 10 cycles after acceptance.
- Backpressure:
  - out_ready=0 for 7 cycles after out_valid: out_data and out_valid are held, in_ready=0, and a new in_valid is ignored.
  - After out_ready=1: handshake completes, and in_ready=1 on the following cycle.
- Reset mid-operation:
  - Drive rst_n=0 at round 5 for one edge: next cycle in_ready=1, out_valid=0, rnd_num=0, busy=0.
  - A following App. C.1 block still yields 69c4e0d8…c55a.
- Back-to-back blocks:
  - Two blocks with in_valid held high and out_ready=1: both ciphertexts are correct.
  - Second acceptance occurs 1 cycle after the first output handshake.
